// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-stream engine.
package fifo_rd_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefLenW      = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StRun   = RUN,
        StFlush = FLUSH,
        StDone  = DONE
    } state_e;

endpackage

// File: rtl/fifo_rd_obuf.sv
// Small in-order register FIFO that holds captured FIFO words until the
// downstream consumer accepts them. Push and pop in one cycle are both honoured.
module fifo_rd_obuf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned BUF_DEPTH  = 3,
    parameter int unsigned OccW       = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [OccW-1:0]       occ_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [OccW-1:0]       occ_q;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Pop only real entries; a push into a full buffer is honoured only alongside a pop.
    assign do_pop  = pop_i && (occ_q != '0);
    assign do_push = push_i && ((occ_q != OccW'(BUF_DEPTH)) || do_pop);

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + OccW'(1);
                2'b01:   occ_q <= occ_q - OccW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a programmed burst of words from the synchronous FIFO read port and
// presents them as a valid/ready stream, flagging the final beat with m_last.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned LEN_W      = DefLenW,
    parameter int unsigned BUF_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      burst_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fifo_cs_o,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o
);

    localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);

    state_e           state_q;
    logic [LEN_W-1:0] rd_rem_q;
    logic [LEN_W-1:0] out_rem_q;
    logic             inflight_q;
    logic             busy_q;
    logic             done_q;

    logic [OccW-1:0]  occ;
    logic [OccW:0]    fill;
    logic             rd_en;
    logic             hs;
    logic             rd_last;
    logic             out_last;

    // Slots already committed: buffered words plus the word arriving next edge.
    assign fill  = {1'b0, occ} + (OccW + 1)'(inflight_q);
    // Issue depends only on registered state, so m_ready never reaches rd_en.
    assign rd_en = (state_q == StRun) && enable_i && !fifo_empty_i &&
                   (rd_rem_q != '0) && (fill < (OccW + 1)'(BUF_DEPTH));

    assign hs       = m_valid_o && m_ready_i;
    assign rd_last  = rd_en && (rd_rem_q == LEN_W'(1));
    assign out_last = hs && (out_rem_q == LEN_W'(1));

    assign fifo_cs_o    = rd_en;
    assign fifo_rd_en_o = rd_en;
    assign m_valid_o    = (occ != '0);
    assign m_last_o     = m_valid_o && (out_rem_q == LEN_W'(1));
    assign busy_o       = busy_q;
    assign done_o       = done_q;

    // Burst FSM with counters; busy/done are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rd_rem_q  <= '0;
            out_rem_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_rem_q <= rd_rem_q - LEN_W'(1);
            end
            if (hs) begin
                out_rem_q <= out_rem_q - LEN_W'(1);
            end
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        rd_rem_q  <= burst_len_i;
                        out_rem_q <= burst_len_i;
                        if (burst_len_i == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (rd_last) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    // Last handshake retires the burst; done follows on the next cycle.
                    if (out_last || (out_rem_q == '0)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A read accepted this cycle returns data on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_en;
        end
    end

    fifo_rd_obuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH),
        .OccW       (OccW)
    ) u_obuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (fifo_data_i),
        .pop_i       (hs),
        .occ_o       (occ),
        .head_o      (m_data_o)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model, scoreboard of burst lengths
// and written words, and a negedge monitor that checks every output beat.
module tb_fifo_rd_stream;

    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int DEPTH = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          busy, done, fifo_cs, fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .LEN_W      (LW),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .start_i      (start),
        .burst_len_i  (burst_len),
        .busy_o       (busy),
        .done_o       (done),
        .fifo_cs_o    (fifo_cs),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_data_i  (fifo_data),
        .fifo_empty_i (fifo_empty),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .m_last_o     (m_last)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] wr_pend[$];
    logic [DW-1:0] model_words[$];
    int            len_q[$];

    bit            in_burst = 0;
    bit            done_exp_next = 0;
    bit            done_exp_now = 0;
    bit            hold_pend = 0;
    bit            rand_mode = 0;
    logic [DW-1:0] hold_data = '0;
    logic [DW-1:0] exp_w;
    int            cur_len = 0, beat_idx = 0;
    int            rd_count = 0, beat_total = 0, reads_out = 0, beats_out = 0;
    int            first_rd = -1, last_rd = -1, first_v = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous FIFO model: registered read data, writes land at the edge.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        while (wr_pend.size() > 0) fifo_q.push_back(wr_pend.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Random backpressure and enable, applied away from the stimulus drive time.
    always @(posedge clk) begin
        if (rand_mode) begin
            #2;
            m_ready = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend     = 0;
            done_exp_next = 0;
        end else begin
            done_exp_now  = done_exp_next;
            done_exp_next = 0;
            if (done || done_exp_now) begin
                chk("done_pulse", done, done_exp_now);
                chk("busy_at_done", busy, 0);
            end
            if (!in_burst && len_q.size() > 0 && len_q[0] == 0) begin
                void'(len_q.pop_front());
                done_exp_next = 1;
            end
            if (fifo_rd_en) begin
                rd_count++;
                reads_out++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                chk("rd_not_empty", fifo_empty, 0);
                chk("rd_enabled", enable, 1);
                chk("cs_eq_rd", fifo_cs, 1);
                chk("outstanding_le_depth", (reads_out - beats_out) <= DEPTH, 1);
            end
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid) chk("busy_while_valid", busy, 1);
            if (m_last && !m_valid) chk("last_needs_valid", m_last, 0);
            if (hold_pend) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, hold_data);
            end
            hold_pend = 0;
            if (m_valid && m_ready) begin
                if (!in_burst && len_q.size() > 0) begin
                    cur_len  = len_q.pop_front();
                    beat_idx = 0;
                    in_burst = 1;
                end
                chk("beat_in_burst", in_burst, 1);
                chk("word_available", model_words.size() > 0, 1);
                if (model_words.size() > 0) begin
                    exp_w = model_words.pop_front();
                    chk("beat_data", m_data, exp_w);
                end
                chk("beat_last", m_last, beat_idx == cur_len - 1);
                beat_idx++;
                beats_out++;
                beat_total++;
                if (in_burst && beat_idx >= cur_len) begin
                    in_burst      = 0;
                    done_exp_next = 1;
                    reads_out     = 0;
                    beats_out     = 0;
                end
            end else if (m_valid) begin
                hold_pend = 1;
                hold_data = m_data;
            end
        end
    end

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        wr_pend.push_back(w);
        model_words.push_back(w);
    endtask

    task automatic start_burst(input int len, output int s);
        s         = cyc;
        burst_len = LW'(len);
        start     = 1'b1;
        len_q.push_back(len);
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        bit got = 0;
        while (n < budget && !got) begin
            @(negedge clk);
            got = done;
            n++;
        end
        chk(name, got, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_burst(input int len);
        int pre = $urandom_range(0, len);
        int s;
        for (int i = 0; i < pre; i++) push_word($urandom);
        step(2);
        start_burst(len, s);
        for (int i = pre; i < len; i++) begin
            step($urandom_range(0, 3));
            push_word($urandom);
        end
        wait_done(4000, "rand_done");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, r0, b0;
        logic [DW-1:0] w0;

        // Reset state.
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_cs", fifo_cs, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        rst_n   = 1'b1;
        enable  = 1'b1;
        m_ready = 1'b1;
        step(2);

        // 1: basic 4-word burst, latency and back-to-back reads.
        for (int i = 0; i < 4; i++) push_word(32'hA0 + i);
        step(2);
        rd_count = 0; first_rd = -1; last_rd = -1; first_v = -1;
        start_burst(4, s);
        wait_done(50, "t1_done");
        chk("t1_rd_count", rd_count, 4);
        chk("t1_first_rd", first_rd, s + 1);
        chk("t1_rd_consec", last_rd - first_rd, 3);
        chk("t1_latency", first_v - first_rd, 2);

        // 2: backpressure holds three reads and a stable head.
        m_ready = 1'b0;
        w0 = $urandom;
        push_word(w0);
        for (int i = 1; i < 8; i++) push_word($urandom);
        step(2);
        rd_count = 0;
        start_burst(8, s);
        step(20);
        chk("t2_reads_held", rd_count, 3);
        chk("t2_valid_held", m_valid, 1);
        chk("t2_head_word", m_data, w0);
        m_ready = 1'b1;
        wait_done(50, "t2_done");
        chk("t2_rd_count", rd_count, 8);

        // 3: FIFO runs dry mid-burst.
        for (int i = 0; i < 3; i++) push_word($urandom);
        step(2);
        rd_count = 0;
        start_burst(6, s);
        step(10);
        chk("t3_busy_stall", busy, 1);
        chk("t3_reads_stall", rd_count, 3);
        for (int i = 0; i < 3; i++) push_word($urandom);
        wait_done(50, "t3_done");
        chk("t3_rd_count", rd_count, 6);

        // 4: zero-length burst.
        rd_count = 0;
        start_burst(0, s);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t4_busy_after", busy, 0);
            chk("t4_done_after", done, 0);
        end
        chk("t4_no_reads", rd_count, 0);

        // 5: start ignored in RUN; enable gap stops reads while output drains.
        for (int i = 0; i < 12; i++) push_word($urandom);
        step(2);
        rd_count = 0;
        start_burst(12, s);
        step(1);
        burst_len = LW'(9);
        start = 1'b1;
        step(1);
        start = 1'b0;
        enable = 1'b0;
        r0 = rd_count;
        b0 = beat_total;
        step(5);
        chk("t5_no_reads_disabled", rd_count - r0, 0);
        chk("t5_drained", (beat_total - b0) > 0, 1);
        enable = 1'b1;
        wait_done(80, "t5_done");
        chk("t5_rd_count", rd_count, 12);

        // 6: asynchronous reset during burst 2 of 5.
        rand_burst(4);
        for (int i = 0; i < 5; i++) push_word($urandom);
        step(2);
        start_burst(5, s);
        step(3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rd_en", fifo_rd_en, 0);
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_last", m_last, 0);
        chk("t6_rst_data", m_data, 0);
        in_burst = 0; reads_out = 0; beats_out = 0;
        len_q.delete(); model_words.delete(); fifo_q.delete(); wr_pend.delete();
        step(2);
        rst_n = 1'b1;
        step(2);
        rand_burst(2);
        rand_burst($urandom_range(1, 10));
        rand_burst($urandom_range(1, 10));

        // Randomized bursts under random backpressure and enable.
        rand_mode = 1;
        for (int i = 0; i < 8; i++) rand_burst($urandom_range(1, 20));
        rand_mode = 0;
        step(1);
        m_ready = 1'b1;
        enable  = 1'b1;
        step(5);
        chk("end_queue_empty", len_q.size(), 0);
        chk("end_words_empty", model_words.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
